multicycle_control_fsm: RTL

MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

---
 rtl/multicycle_control_fsm.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I control FSM.
// Moore controls are registered from the next state; fetch strobes follow mem_ready.
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       ALUSrcA,
    output logic       PCSource,
    output logic [1:0] MemToReg,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [3:0] state_o,
    output logic       illegal_o
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB_ALU   = 4'd7,
        WB_MEM   = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        LUI      = 4'd11,
        TRAP     = 4'd12
    } state_t;

    state_t state;
    state_t nxt;
    logic   run;
    logic   is_store;
    logic   jal_pcw;
    logic   fetch_go;

    // zero only matters to the datapath (it gates PCWriteCond there)
    logic   unused_zero;
    assign unused_zero = zero;

    // run holds the machine idle in FETCH for the first edge after reset
    assign fetch_go = run && (state == FETCH) && mem_ready;
    assign IRWrite  = fetch_go;
    assign PCWrite  = jal_pcw | fetch_go;
    assign state_o  = state;

    // Next-state selection
    always_comb begin
        nxt = state;
        if (!run) begin
            nxt = FETCH;
        end else begin
            case (state)
                FETCH:    nxt = mem_ready ? DECODE : FETCH;
                DECODE: begin
                    case (opcode)
                        7'b0110011: nxt = EXEC_R;
                        7'b0010011: nxt = EXEC_I;
                        7'b0000011: nxt = MEM_ADDR;
                        7'b0100011: nxt = MEM_ADDR;
                        7'b1100011: nxt = BRANCH;
                        7'b1101111: nxt = JAL;
                        7'b0110111: nxt = LUI;
                        default:    nxt = TRAP;
                    endcase
                end
                EXEC_R:   nxt = WB_ALU;
                EXEC_I:   nxt = WB_ALU;
                MEM_ADDR: nxt = is_store ? MEM_WR : MEM_RD;
                MEM_RD:   nxt = mem_ready ? WB_MEM : MEM_RD;
                MEM_WR:   nxt = mem_ready ? FETCH : MEM_WR;
                WB_ALU:   nxt = FETCH;
                WB_MEM:   nxt = FETCH;
                BRANCH:   nxt = FETCH;
                JAL:      nxt = FETCH;
                LUI:      nxt = FETCH;
                TRAP:     nxt = TRAP;
                default:  nxt = FETCH;
            endcase
        end
    end

    // State register with Moore controls decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            run         <= 1'b0;
            is_store    <= 1'b0;
            jal_pcw     <= 1'b0;
            PCWriteCond <= 1'b0;
            IorD        <= 1'b0;
            RegWrite    <= 1'b0;
            MemRead     <= 1'b0;
            MemWrite    <= 1'b0;
            ALUSrcA     <= 1'b0;
            PCSource    <= 1'b0;
            MemToReg    <= 2'b00;
            ALUSrcB     <= 2'b00;
            ALUOp       <= 2'b00;
            illegal_o   <= 1'b0;
        end else begin
            state <= nxt;
            run   <= 1'b1;
            if (state == DECODE) begin
                is_store <= (opcode == 7'b0100011);
            end
            jal_pcw     <= 1'b0;
            PCWriteCond <= 1'b0;
            IorD        <= 1'b0;
            RegWrite    <= 1'b0;
            MemRead     <= 1'b0;
            MemWrite    <= 1'b0;
            ALUSrcA     <= 1'b0;
            PCSource    <= 1'b0;
            MemToReg    <= 2'b00;
            ALUSrcB     <= 2'b00;
            ALUOp       <= 2'b00;
            illegal_o   <= 1'b0;
            case (nxt)
                FETCH: begin
                    MemRead <= 1'b1;
                    ALUSrcB <= 2'b01;
                end
                DECODE: begin
                    ALUSrcB <= 2'b10;
                end
                EXEC_R: begin
                    ALUSrcA <= 1'b1;
                    ALUOp   <= 2'b10;
                end
                EXEC_I: begin
                    ALUSrcA <= 1'b1;
                    ALUSrcB <= 2'b10;
                    ALUOp   <= 2'b10;
                end
                MEM_ADDR: begin
                    ALUSrcA <= 1'b1;
                    ALUSrcB <= 2'b10;
                end
                MEM_RD: begin
                    MemRead <= 1'b1;
                    IorD    <= 1'b1;
                end
                MEM_WR: begin
                    MemWrite <= 1'b1;
                    IorD     <= 1'b1;
                end
                WB_ALU: begin
                    RegWrite <= 1'b1;
                end
                WB_MEM: begin
                    RegWrite <= 1'b1;
                    MemToReg <= 2'b01;
                end
                BRANCH: begin
                    ALUSrcA     <= 1'b1;
                    ALUOp       <= 2'b01;
                    PCWriteCond <= 1'b1;
                    PCSource    <= 1'b1;
                end
                JAL: begin
                    RegWrite <= 1'b1;
                    MemToReg <= 2'b10;
                    jal_pcw  <= 1'b1;
                    PCSource <= 1'b1;
                end
                LUI: begin
                    RegWrite <= 1'b1;
                    MemToReg <= 2'b11;
                end
                TRAP: begin
                    illegal_o <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
